sram_controller: RTL and testbench

- Responder side of the cache-to-SRAM request interface.
- Accepts one-word writes and 64-bit (two-word) block reads from the cache controller.
- Sequences them as 16-bit accesses on the external asynchronous 256K x 16 SRAM.
- Returns one `ready` pulse per completed request.
- Sits between the memory-stage cache controller and the board SRAM pins.

---
 rtl/sram_controller.sv | 146 ++++++++++++++
 tb/tb_sram_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Cache-to-SRAM responder: one-word writes and 64-bit block reads sequenced as 16-bit accesses.
// Optional SRAM_ADDR_RANGE_CHECK_EN rejects out-of-range requests with addr_err.
`timescale 1ns/1ps

module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned ADDR_BASE     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [63:0] rdata,
    output logic        ready,
    output logic        addr_err,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_CYC = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [1:0]    slot, slot_n;
    logic [31:0]   wdata_q, wdata_n;
    logic [63:0]   rdata_q, rdata_n;
    logic [17:0]   sram_addr_q, sram_addr_n;
    logic          we_n_q, we_n_n;
    logic          oe_n_q, oe_n_n;
    logic          err_q, err_n;
    logic          last_cyc, last_slot;
    logic [16:0]   req_word;

    // Halfword-pair index of the request, wrapped into the 2^19-byte SRAM window
    assign req_word = 17'((address - 32'(ADDR_BASE)) >> 2);

`ifdef SRAM_ADDR_RANGE_CHECK_EN
    logic req_err;
    assign req_err = (address < 32'(ADDR_BASE)) ||
                     ((address - 32'(ADDR_BASE)) >= 32'h0008_0000);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cyc         <= '0;
            slot        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state       <= state_n;
            cyc         <= cyc_n;
            slot        <= slot_n;
            wdata_q     <= wdata_n;
            rdata_q     <= rdata_n;
            sram_addr_q <= sram_addr_n;
            we_n_q      <= we_n_n;
            oe_n_q      <= oe_n_n;
            err_q       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cyc_n       = cyc;
        slot_n      = slot;
        wdata_n     = wdata_q;
        rdata_n     = rdata_q;
        sram_addr_n = sram_addr_q;
        err_n       = 1'b0;
        last_cyc    = (cyc == LAST_CYC);
        last_slot   = (state == READ) ? (slot == 2'd3) : (slot == 2'd1);

        case (state)
            IDLE: begin
                if (read_en || write_en) begin
                    cyc_n   = '0;
                    slot_n  = '0;
                    wdata_n = wdata;
`ifdef SRAM_ADDR_RANGE_CHECK_EN
                    if (req_err) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                        if (read_en) rdata_n = '0;
                    end else
`endif
                    if (read_en) begin
                        state_n     = READ;
                        sram_addr_n = {req_word[16:1], 2'b00};
                    end else begin
                        state_n     = WRITE;
                        sram_addr_n = {req_word, 1'b0};
                    end
                end
            end
            READ, WRITE: begin
                // Async SRAM data is settled by the last cycle of the slot
                if (state == READ && last_cyc) rdata_n[{slot, 4'b0000} +: 16] = SRAM_DQ;
                if (last_cyc) begin
                    cyc_n = '0;
                    if (last_slot) begin
                        state_n = DONE;
                        slot_n  = '0;
                    end else begin
                        slot_n      = slot + 2'd1;
                        sram_addr_n = sram_addr_q + 18'd1;
                    end
                end else begin
                    cyc_n = cyc + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // WE_N rises one cycle before the slot ends so address/data hold past it
        we_n_n = !((state_n == WRITE) && (cyc_n != LAST_CYC));
        oe_n_n = (state_n != READ);
    end

    assign ready     = (state == DONE) || ((state == IDLE) && !read_en && !write_en);
    assign rdata     = rdata_q;
    assign addr_err  = err_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = (state == WRITE) ? (slot[0] ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (ACCESS_CYCLES 2 and 3), each on its own SRAM model,
// checked against a halfword-array reference of SRAM contents.
`timescale 1ns/1ps

module tb_sram_controller;

    localparam int unsigned BASE = 1024;
    localparam int unsigned MEMW = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel, read_en, write_en, probe;
    logic [31:0] address, wdata;

    logic [63:0] rdata2, rdata3;
    logic        ready2, ready3, err2, err3, we2, we3, oe2, oe3;
    logic        ce2, ub2, lb2, ce3, ub3, lb3;
    logic [17:0] addr2, addr3;
    wire  [15:0] dq2, dq3;
    logic        rd2, wr2, rd3, wr3;

    logic [15:0] mem2 [MEMW] = '{default: 16'h0};
    logic [15:0] mem3 [MEMW] = '{default: 16'h0};
    logic [15:0] ref_mem [2][MEMW];
    logic [63:0] last_rd [2];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rd2 = read_en & ~sel;
    assign wr2 = write_en & ~sel;
    assign rd3 = read_en & sel;
    assign wr3 = write_en & sel;

    sram_controller #(.ACCESS_CYCLES(2), .ADDR_BASE(BASE)) u_dut2 (
        .clk(clk), .rst(rst), .read_en(rd2), .write_en(wr2), .address(address), .wdata(wdata),
        .rdata(rdata2), .ready(ready2), .addr_err(err2), .SRAM_DQ(dq2), .SRAM_ADDR(addr2),
        .SRAM_WE_N(we2), .SRAM_OE_N(oe2), .SRAM_CE_N(ce2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2)
    );

    sram_controller #(.ACCESS_CYCLES(3), .ADDR_BASE(BASE)) u_dut3 (
        .clk(clk), .rst(rst), .read_en(rd3), .write_en(wr3), .address(address), .wdata(wdata),
        .rdata(rdata3), .ready(ready3), .addr_err(err3), .SRAM_DQ(dq3), .SRAM_ADDR(addr3),
        .SRAM_WE_N(we3), .SRAM_OE_N(oe3), .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3)
    );

    // Asynchronous SRAM models: read while OE_N low, latch on WE_N rising edge
    assign dq2 = (!oe2 && we2) ? mem2[addr2] : (probe ? 16'hA5C3 : 16'bz);
    assign dq3 = (!oe3 && we3) ? mem3[addr3] : (probe ? 16'hA5C3 : 16'bz);
    always @(posedge we2) if (!rst) mem2[addr2] <= dq2;
    always @(posedge we3) if (!rst) mem3[addr3] <= dq3;

    logic        ready_o, err_o, oe_o, we_o;
    logic [63:0] rdata_o;
    logic [17:0] addr_o;
    assign ready_o = sel ? ready3 : ready2;
    assign err_o   = sel ? err3   : err2;
    assign oe_o    = sel ? oe3    : oe2;
    assign we_o    = sel ? we3    : we2;
    assign rdata_o = sel ? rdata3 : rdata2;
    assign addr_o  = sel ? addr3  : addr2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_at(input logic s, input logic [17:0] i);
        return s ? mem3[i] : mem2[i];
    endfunction

    // One request, checked against the reference: latency, strobes, addresses, data, memory
    task automatic txn(input logic s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic scr);
        int          ac, si, n, oe_cnt, we_cnt, exp_edges;
        logic        err, got;
        logic [31:0] off;
        logic [17:0] rbase, wbase;
        logic [63:0] exp_rd;
        ac  = s ? 3 : 2;
        si  = s ? 1 : 0;
        off = a - BASE;
`ifdef SRAM_ADDR_RANGE_CHECK_EN
        err = (a < BASE) || (off >= 32'h80000);
`else
        err = 1'b0;
`endif
        wbase = 18'((off % 32'h80000) / 4 * 2);
        rbase = 18'((off % 32'h80000) / 8 * 4);
        if (rd)
            exp_rd = err ? 64'h0 : {ref_mem[si][18'(rbase + 3)], ref_mem[si][18'(rbase + 2)],
                                    ref_mem[si][18'(rbase + 1)], ref_mem[si][rbase]};
        else
            exp_rd = last_rd[si];
        exp_edges = err ? 1 : (rd ? 4 * ac : 2 * ac) + 1;

        @(negedge clk);
        sel = s; read_en = rd; write_en = wr; address = a; wdata = wd;
        #1;
        chk("ready_drop", 64'(ready_o), 64'(0));

        n = 0; oe_cnt = 0; we_cnt = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (scr) begin address = $urandom; wdata = $urandom; end
            if (ready_o) got = 1'b1;
            else begin
                if (!oe_o) oe_cnt++;
                if (!we_o) we_cnt++;
                if (!oe_o || !we_o)
                    chk("sram_addr", 64'(addr_o), 64'((rd ? rbase : wbase) + 18'((n - 1) / ac)));
            end
        end
        chk("latency_edges", 64'(n), 64'(exp_edges));
        chk("rdata_done", rdata_o, exp_rd);
        chk("addr_err_done", 64'(err_o), 64'(err));
        chk("strobes_done", 64'({oe_o, we_o}), 64'(2'b11));
        chk("oe_low_cycles", 64'(oe_cnt), 64'((rd && !err) ? 4 * ac : 0));
        chk("we_low_cycles", 64'(we_cnt), 64'((!rd && wr && !err) ? 2 * (ac - 1) : 0));

        @(negedge clk);
        read_en = 1'b0; write_en = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 64'(ready_o), 64'(1));
        chk("idle_addr_err", 64'(err_o), 64'(0));
        chk("rdata_hold", rdata_o, exp_rd);

        if (!rd && wr && !err) begin
            ref_mem[si][wbase]            = wd[15:0];
            ref_mem[si][18'(wbase + 1)]   = wd[31:16];
        end
        last_rd[si] = exp_rd;
        chk("mem_lo", 64'(mem_at(s, wbase)), 64'(ref_mem[si][wbase]));
        chk("mem_hi", 64'(mem_at(s, 18'(wbase + 1))), 64'(ref_mem[si][18'(wbase + 1)]));
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", 64'(ready2), 64'(1));
        chk("rst_we_n", 64'(we2), 64'(1));
        chk("rst_oe_n", 64'(oe2), 64'(1));
        chk("rst_rdata", rdata2, 64'h0);
        chk("rst_rdata3", rdata3, 64'h0);
        chk("rst_addr_err", 64'(err2), 64'(0));
        chk("rst_sram_addr", 64'(addr2), 64'(0));
        probe = 1'b1;
        #1;
        chk("rst_dq_released", 64'(dq2), 64'(16'hA5C3));
        probe = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        sel = 1'b0; read_en = 1'b0; write_en = 1'b0; probe = 1'b0;
        address = '0; wdata = '0;
        for (int i = 0; i < int'(MEMW); i++) begin
            ref_mem[0][i] = '0;
            ref_mem[1][i] = '0;
        end
        last_rd[0] = '0;
        last_rd[1] = '0;

        repeat (3) @(negedge clk);
        chk_reset_state();
        chk("tied_pins", 64'({ce2, ub2, lb2, ce3, ub3, lb3}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        txn(1'b0, 1'b0, 1'b1, 32'd1024, 32'h1234_5678, 1'b0);
        chk("w1024_hw0", 64'(mem2[0]), 64'(16'h5678));
        chk("w1024_hw1", 64'(mem2[1]), 64'(16'h1234));
        txn(1'b0, 1'b0, 1'b1, 32'd1028, 32'hAABB_CCDD, 1'b1);
        txn(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        chk("block_1024", rdata2, 64'hAABBCCDD_12345678);
        txn(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
        chk("block_1028", rdata2, 64'hAABBCCDD_12345678);
        txn(1'b0, 1'b1, 1'b1, 32'd1032, 32'hDEAD_BEEF, 1'b0);
        chk("both_no_write", 64'(mem2[4]), 64'(0));

        txn(1'b1, 1'b0, 1'b1, 32'd1024, 32'hCAFE_F00D, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0BAD_C0DE, 1'b0);
        txn(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        chk("ac3_block", rdata3, 64'h0BADC0DE_CAFEF00D);

        txn(1'b0, 1'b1, 1'b0, 32'd512, 32'h0, 1'b0);

        // Reset in the middle of a read
        @(negedge clk);
        sel = 1'b0; read_en = 1'b1; address = 32'd1024;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1; read_en = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        txn(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        chk("block_after_rst", rdata2, 64'hAABBCCDD_12345678);

        for (int t = 0; t < 60; t++) begin
            case ($urandom % 8)
                0:       a = $urandom % BASE;
                1:       a = BASE + 32'h80000 + ($urandom % 256);
                default: a = BASE + ($urandom % 256);
            endcase
            op = int'($urandom % 4);
            txn(1'($urandom % 2), op != 2, op >= 2, a, $urandom, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
